// File: rtl/npc_mem_pkg.sv
// Shared types for the fetch/LSU memory arbiter: FSM states, owner tags, bus widths.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package npc_mem_pkg;

  localparam int MEM_AW = 64;
  localparam int MEM_DW = 64;

  // Transaction phases: waiting for a requester, presenting to memory, awaiting data.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Which requester owns the single outstanding transaction.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin pick between instruction fetch and LSU, with last-grant memory.
// Latency: grants are combinational from the requests; last-grant updates on the next edge.
// Backpressure: grants only while en=1; last-grant moves only when a grant is actually issued.
module rr_arb2
  import npc_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_if,
  input  logic req_lsu,
  output logic gnt_if,
  output logic gnt_lsu
);

  owner_e last_q;
  owner_e last_d;
  logic   pick_if;

  // Pick the requester not granted last; a lone requester always wins.
  always_comb begin
    pick_if = req_if & (~req_lsu | (last_q == OWN_LSU));
    gnt_if  = en & pick_if;
    gnt_lsu = en & req_lsu & ~pick_if;
    last_d  = last_q;
    if (gnt_if) begin
      last_d = OWN_IF;
    end else if (gnt_lsu) begin
      last_d = OWN_LSU;
    end
  end

  // Last-grant register; reset to LSU so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= OWN_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates fetch and LSU requests onto one memory port, one transaction in flight.
// Latency: accept at N, mem_req_valid at N+1, response same cycle as mem_resp_valid in WAIT.
// Backpressure: requesters see ready only in IDLE; ISSUE holds fields until mem_req_ready.
module mem_arb
  import npc_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req_valid,
  input  logic [AW-1:0]     if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DW-1:0]     if_resp_data,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_we,
  input  logic [AW-1:0]     lsu_req_addr,
  input  logic [DW-1:0]     lsu_req_wdata,
  input  logic [DW/8-1:0]   lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [DW-1:0]     lsu_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [AW-1:0]     mem_req_addr,
  output logic [DW-1:0]     mem_req_wdata,
  output logic [DW/8-1:0]   mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DW-1:0]     mem_resp_data
);

  typedef struct packed {
    logic              we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wmask;
  } req_t;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  req_t   req_q,   req_d;

  logic   arb_en;
  logic   gnt_if;
  logic   gnt_lsu;
  logic   resp_hit;

  // Arbitration is only offered in IDLE and never while reset is held.
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .en      (arb_en),
    .req_if  (if_req_valid),
    .req_lsu (lsu_req_valid),
    .gnt_if  (gnt_if),
    .gnt_lsu (gnt_lsu)
  );

  // Next-state, owner and request latch; fetch is a plain read with no byte enables.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (gnt_if) begin
          state_d     = ISSUE;
          owner_d     = OWN_IF;
          req_d.we    = 1'b0;
          req_d.addr  = if_req_addr;
          req_d.wdata = '0;
          req_d.wmask = '0;
        end else if (gnt_lsu) begin
          state_d     = ISSUE;
          owner_d     = OWN_LSU;
          req_d.we    = lsu_req_we;
          req_d.addr  = lsu_req_addr;
          req_d.wdata = lsu_req_wdata;
          req_d.wmask = lsu_req_wmask;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  // Handshake and response outputs; everything is forced low while reset is held.
  always_comb begin
    resp_hit       = !reset && (state_q == WAIT) && mem_resp_valid;
    if_req_ready   = gnt_if;
    lsu_req_ready  = gnt_lsu;
    mem_req_valid  = !reset && (state_q == ISSUE);
    if_resp_valid  = resp_hit && (owner_q == OWN_IF);
    lsu_resp_valid = resp_hit && (owner_q == OWN_LSU);
    if_resp_data   = if_resp_valid  ? mem_resp_data : '0;
    lsu_resp_data  = lsu_resp_valid ? mem_resp_data : '0;
    mem_req_we     = req_q.we;
    mem_req_addr   = req_q.addr;
    mem_req_wdata  = req_q.wdata;
    mem_req_wmask  = req_q.wmask;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter AW, default 64, SHALL set the address width.
REQ-002 Parameter DW, default 64, SHALL set the data width; the write mask width SHALL be DW/8.
REQ-003 clk  in  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 if_req_valid  in  1  SHALL indicate an instruction-fetch read request.
REQ-006 if_req_addr  in  AW  SHALL carry the fetch address (PC).
REQ-007 if_req_ready  out  1  SHALL indicate that the fetch request is accepted this cycle.
REQ-008 if_resp_valid  out  1  SHALL pulse for one cycle when fetch data is returned.
REQ-009 if_resp_data  out  DW  SHALL carry the full fetch word; 32-bit lane selection belongs to the fetch stage.
REQ-010 lsu_req_valid / lsu_req_ready  in/out  1  SHALL be the LSU request handshake.
REQ-011 lsu_req_we  in  1  SHALL select write (1) or read (0).
REQ-012 lsu_req_addr  in  AW  SHALL carry the LSU address.
REQ-013 lsu_req_wdata  in  DW  SHALL carry the LSU write data.
REQ-014 lsu_req_wmask  in  DW/8  SHALL carry the LSU byte-enable mask.
REQ-015 lsu_resp_valid / lsu_resp_data  out  1/DW  SHALL be the LSU response pulse and its read data; writes SHALL also get a response pulse.
REQ-016 mem_req_valid / mem_req_ready  out/in  1  SHALL be the memory request handshake.
REQ-017 mem_req_we / mem_req_addr / mem_req_wdata / mem_req_wmask  out  1/AW/DW/DW/8  SHALL carry the latched request fields.
REQ-018 mem_resp_valid / mem_resp_data  in  1/DW  SHALL carry the memory response.

Function
REQ-019 The arbiter SHALL be an FSM with states IDLE, ISSUE and WAIT, and SHALL allow at most one outstanding transaction.
REQ-020 In IDLE with any request valid, the arbiter SHALL assert exactly one req_ready combinationally in that cycle, latch that requester's fields and owner, and move to ISSUE.
REQ-021 Tie-break SHALL be round-robin: the winner is the requester not granted last; a lone requester always wins.
REQ-022 The last-grant register SHALL update only on acceptance.
REQ-023 In ISSUE, mem_req_valid SHALL be 1 with stable latched fields until mem_req_ready=1; the arbiter SHALL then move to WAIT.
REQ-024 For an IF-owned transaction, mem_req_we=0 and mem_req_wmask=0 SHALL hold.
REQ-025 In WAIT, mem_resp_valid=1 SHALL raise the owner's resp_valid in the same cycle with resp_data=mem_resp_data, and the FSM SHALL return to IDLE.
REQ-026 Both req_ready outputs SHALL be 0 in ISSUE and WAIT.
REQ-027 mem_resp_valid in IDLE or ISSUE SHALL be ignored.
REQ-028 The non-owner's resp_valid SHALL stay 0.
REQ-029 Minimum latency SHALL be: acceptance at cycle N, mem_req_valid at N+1, resp_valid at N+2 when memory responds one cycle after accept; back-to-back acceptance SHALL be possible in the cycle after the response.
REQ-030 Address and data SHALL pass through unmodified, with no alignment check.
REQ-031 Outside ISSUE, mem_req_valid SHALL be 0 and the other mem_req_* fields SHALL hold their last latched values.

Reset
REQ-032 While reset=1, the FSM SHALL go to IDLE, last-grant SHALL be LSU (so IF wins the first tie), and the latched fields SHALL be 0.
REQ-033 While reset=1, all ready, valid and resp outputs SHALL be 0.
REQ-034 A reset during ISSUE or WAIT SHALL abandon the transaction with no response pulse; a later stale mem_resp_valid SHALL be ignored.

Structure
REQ-035 Package npc_mem_pkg SHALL hold the state enum {IDLE, ISSUE, WAIT}, the owner enum {OWN_IF, OWN_LSU}, and the AW/DW defaults.
REQ-036 Sub-module rr_arb2 SHALL implement the two-way round-robin pick and last-grant register; the FSM and request latches SHALL stay in mem_arb.

Verification
REQ-037 Scenario: IF only, addr 0x8000_0004, memory accepts at once and responds next cycle with 0x0010_0093_0000_0413 -> if_req_ready at N, mem_req_valid at N+1, if_resp_valid at N+2 with that data, lsu_resp_valid=0.
REQ-038 Scenario: IF and LSU valid together, twice in succession after reset -> IF granted first, LSU second.
REQ-039 Scenario: LSU write addr 0x8000_1000, wdata 0xDEAD_BEEF_0000_0001, wmask 0x0F, mem_req_ready held low 3 cycles -> mem_req fields stable over those cycles, mem_req_we=1, single lsu_resp_valid pulse.
REQ-040 Scenario: spurious mem_resp_valid in IDLE, and again in ISSUE -> no resp_valid on either port.
REQ-041 Scenario: reset asserted in WAIT, then mem_resp_valid arrives -> no response pulse; the next IF request completes normally.
